filter_capture: RTL and testbench

FILTER_CAPTURE -- requirements
Module: filter_capture

---
 rtl/filter_capture_pkg.sv | 15 +
 rtl/filter_capture_mem.sv | 33 +++
 rtl/filter_capture.sv | 161 ++++++++++++++++
 tb/tb_filter_capture.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_capture_pkg.sv
// Shared sizing defaults and FSM state encoding for the filter output capture buffer.
package filter_capture_pkg;

    localparam int unsigned DEPTH_DEF  = 2000;
    localparam int unsigned DATA_W_DEF = 10;
    localparam int unsigned ADDR_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/filter_capture_mem.sv
// Simple dual-port sample store: one synchronous write port, one synchronous read port, no reset.
module filter_capture_mem
    import filter_capture_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Read data only changes when rd_en is asserted, so a stalled reader sees it held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= store[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/filter_capture.sv
// Captures DEPTH filter output samples qualified by clk_enable, then replays them
// over a valid/ready stream with one sample prefetched from the store.
module filter_capture
    import filter_capture_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clk_enable,
    input  logic [DATA_W-1:0] sample_in,
    output logic [ADDR_W-1:0] sample_count,
    output logic              capture_done,
    output logic              overflow,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FULL_CNT  = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] sample_count_q, sample_count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              capture_done_q, capture_done_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_last_q, rd_last_d;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    filter_capture_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr_q),
        .wr_data (sample_in),
        .rd_en   (mem_re),
        .rd_addr (mem_raddr),
        .rd_data (mem_rdata)
    );

    // Next-state, store control and output register inputs.
    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        sample_count_d = sample_count_q;
        rd_ptr_d       = rd_ptr_q;
        overflow_d     = overflow_q;
        rd_valid_d     = rd_valid_q;
        rd_data_d      = rd_data_q;
        rd_last_d      = rd_last_q;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_raddr      = rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_CAPTURE;
                    wr_addr_d      = '0;
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (clk_enable) begin
                    mem_we         = 1'b1;
                    wr_addr_d      = wr_addr_q + ADDR_W'(1);
                    sample_count_d = sample_count_q + ADDR_W'(1);
                    // Start fetching entry 0 on the final write so it is presented one cycle later.
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = ST_DRAIN;
                        mem_re    = 1'b1;
                        mem_raddr = '0;
                        rd_ptr_d  = ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (clk_enable) begin
                    overflow_d = 1'b1;
                end
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    state_d    = ST_DONE;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else if (!rd_valid_q || rd_ready) begin
                    // Load the prefetched sample and fetch the one after it.
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_rdata;
                    rd_last_d  = (rd_ptr_q == FULL_CNT);
                    if (rd_ptr_q < FULL_CNT) begin
                        mem_re   = 1'b1;
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d        = ST_CAPTURE;
                    wr_addr_d      = '0;
                    sample_count_d = '0;
                    overflow_d     = 1'b0;
                end else if (clk_enable) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        capture_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_addr_q      <= '0;
            sample_count_q <= '0;
            rd_ptr_q       <= '0;
            capture_done_q <= 1'b0;
            overflow_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            sample_count_q <= sample_count_d;
            rd_ptr_q       <= rd_ptr_d;
            capture_done_q <= capture_done_d;
            overflow_q     <= overflow_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_last_q      <= rd_last_d;
        end
    end

    assign sample_count = sample_count_q;
    assign capture_done = capture_done_q;
    assign overflow     = overflow_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;

endmodule

// File: tb/tb_filter_capture.sv
// Scoreboard bench for filter_capture: captured samples are queued as driven and
// compared against the replayed stream.
module tb_filter_capture;

    localparam int unsigned DEPTH  = 2000;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              clk_enable = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [ADDR_W-1:0] sample_count;
    logic              capture_done;
    logic              overflow;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];

    filter_capture dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clk_enable   (clk_enable),
        .sample_in    (sample_in),
        .sample_count (sample_count),
        .capture_done (capture_done),
        .overflow     (overflow),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives n enabled samples (optionally interleaved with idle cycles) and queues them.
    task automatic capture(input int n, input bit toggle, input int base,
                           input int start_at, output int cycles);
        int  k;
        bit  en;
        k = 0;
        cycles = 0;
        while (k < n && cycles < 10000) begin
            en         = toggle ? (cycles % 2 == 1) : 1'b1;
            clk_enable = en;
            sample_in  = DATA_W'((base + k) % 1024);
            start      = en && (k == start_at);
            if (en) begin
                exp_q.push_back(sample_in);
                k++;
            end
            tick();
            cycles++;
        end
        clk_enable = 1'b0;
        start      = 1'b0;
    endtask

    // Collects transferred samples into got_q and tallies protocol observations.
    task automatic drain(input int pct, output int xfers, output int unstable,
                         output int last_bad);
        logic [DATA_W-1:0] hold_d;
        logic              hold_l;
        bit                stalled;
        stalled  = 1'b0;
        hold_d   = '0;
        hold_l   = 1'b0;
        xfers    = 0;
        unstable = 0;
        last_bad = 0;
        got_q.delete();
        for (int cyc = 0; cyc < 12000 && xfers < int'(DEPTH); cyc++) begin
            rd_ready = ($urandom_range(99) < pct);
            if (stalled && (rd_valid !== 1'b1 || rd_data !== hold_d || rd_last !== hold_l))
                unstable++;
            stalled = 1'b0;
            if (rd_valid === 1'b1) begin
                if (rd_ready) begin
                    got_q.push_back(rd_data);
                    if (rd_last !== (xfers == int'(DEPTH) - 1)) last_bad++;
                    xfers++;
                end else begin
                    stalled = 1'b1;
                    hold_d  = rd_data;
                    hold_l  = rd_last;
                end
            end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (sample_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", sample_count); end
        checks++; if (capture_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", capture_done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin failures++; $display("FAIL reset_rd_last got=%b want=0", rd_last); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h want=000", rd_data); end
        // clk_enable in IDLE must be ignored
        clk_enable = 1'b1;
        repeat (5) tick();
        clk_enable = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL idle_overflow got=%b want=0", overflow); end
        checks++; if (sample_count !== '0) begin failures++; $display("FAIL idle_count got=%0d want=0", sample_count); end
    endtask

    task automatic test_full_run();
        int cyc, xf, unst, lb, bad;
        logic [DATA_W-1:0] e, g;
        exp_q.delete();
        arm();
        checks++; if (sample_count !== '0) begin failures++; $display("FAIL full_armed_count got=%0d want=0", sample_count); end
        capture(DEPTH, 1'b0, 0, -1, cyc);
        checks++; if (sample_count !== ADDR_W'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d want=%0d", sample_count, DEPTH); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL full_drain_entry_valid got=%b want=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin failures++; $display("FAIL full_first_word valid=%b data=%h want valid=1 data=000", rd_valid, rd_data); end
        drain(100, xf, unst, lb);
        checks++; if (xf != int'(DEPTH)) begin failures++; $display("FAIL full_xfers got=%0d want=%0d", xf, DEPTH); end
        checks++; if (lb != 0) begin failures++; $display("FAIL full_rd_last errors=%0d want=0", lb); end
        bad = 0; e = '0; g = '0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            if (exp_q[0] !== got_q[0] && bad == 0) begin e = exp_q[0]; g = got_q[0]; end
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        end
        checks++; if (bad != 0 || exp_q.size() != 0) begin failures++; $display("FAIL full_data mismatches=%0d left=%0d first got=%h want=%h", bad, exp_q.size(), g, e); end
        checks++; if (rd_valid !== 1'b0 || capture_done !== 1'b1) begin failures++; $display("FAIL full_done valid=%b done=%b want valid=0 done=1", rd_valid, capture_done); end
    endtask

    task automatic test_toggle_enable();
        int cyc, xf, unst, lb, bad;
        exp_q.delete();
        arm();
        capture(DEPTH, 1'b1, 300, -1, cyc);
        checks++; if (cyc != 2 * int'(DEPTH)) begin failures++; $display("FAIL toggle_cycles got=%0d want=%0d", cyc, 2 * DEPTH); end
        checks++; if (sample_count !== ADDR_W'(DEPTH)) begin failures++; $display("FAIL toggle_count got=%0d want=%0d", sample_count, DEPTH); end
        drain(100, xf, unst, lb);
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0)
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        checks++; if (bad != 0 || exp_q.size() != 0 || got_q.size() != 0) begin failures++; $display("FAIL toggle_data mismatches=%0d exp_left=%0d got_left=%0d want all 0", bad, exp_q.size(), got_q.size()); end
    endtask

    task automatic test_backpressure();
        int cyc, xf, unst, lb, bad;
        exp_q.delete();
        arm();
        capture(DEPTH, 1'b0, 77, -1, cyc);
        drain(50, xf, unst, lb);
        checks++; if (xf != int'(DEPTH)) begin failures++; $display("FAIL bp_xfers got=%0d want=%0d", xf, DEPTH); end
        checks++; if (unst != 0) begin failures++; $display("FAIL bp_stability unstable_cycles=%0d want=0", unst); end
        checks++; if (lb != 0) begin failures++; $display("FAIL bp_rd_last errors=%0d want=0", lb); end
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0)
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        checks++; if (bad != 0 || exp_q.size() != 0) begin failures++; $display("FAIL bp_data mismatches=%0d left=%0d want 0", bad, exp_q.size()); end
    endtask

    task automatic test_overflow();
        int cyc, xf, unst, lb, bad;
        exp_q.delete();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b want=0", overflow); end
        clk_enable = 1'b1;
        repeat (5) tick();
        clk_enable = 1'b0;
        checks++; if (overflow !== 1'b1 || capture_done !== 1'b1) begin failures++; $display("FAIL ovf_set ovf=%b done=%b want 1/1", overflow, capture_done); end
        // start coincident with a valid sample: sample is dropped, capture begins next cycle
        start = 1'b1; clk_enable = 1'b1; sample_in = 10'h3E7;
        tick();
        start = 1'b0; clk_enable = 1'b0;
        checks++; if (overflow !== 1'b0 || sample_count !== '0) begin failures++; $display("FAIL ovf_clear ovf=%b count=%0d want 0/0", overflow, sample_count); end
        capture(DEPTH, 1'b0, 500, -1, cyc);
        drain(100, xf, unst, lb);
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0)
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        checks++; if (bad != 0 || exp_q.size() != 0) begin failures++; $display("FAIL ovf_fresh_data mismatches=%0d left=%0d want 0", bad, exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_after_run got=%b want=0", overflow); end
    endtask

    task automatic test_reset_mid();
        int cyc, xf, unst, lb, bad, seen;
        exp_q.delete();
        arm();
        capture(1000, 1'b0, 0, -1, cyc);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        checks++; if (sample_count !== '0 || rd_valid !== 1'b0 || capture_done !== 1'b0) begin failures++; $display("FAIL midcap_reset count=%0d valid=%b done=%b want 0/0/0", sample_count, rd_valid, capture_done); end
        clk_enable = 1'b1;
        repeat (3) tick();
        clk_enable = 1'b0;
        checks++; if (sample_count !== '0) begin failures++; $display("FAIL midcap_idle_count got=%0d want=0", sample_count); end
        arm();
        capture(DEPTH, 1'b0, 900, -1, cyc);
        drain(100, xf, unst, lb);
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0)
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        checks++; if (xf != int'(DEPTH) || bad != 0) begin failures++; $display("FAIL midcap_rerun xfers=%0d mismatches=%0d want %0d/0", xf, bad, DEPTH); end
        // abort during readout
        exp_q.delete();
        arm();
        capture(DEPTH, 1'b0, 0, -1, cyc);
        rd_ready = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            if (rd_valid !== 1'b0) seen++;
            tick();
        end
        rd_ready = 1'b0;
        exp_q.delete();
        checks++; if (seen != 0) begin failures++; $display("FAIL middrain_abort valid_cycles=%0d want=0", seen); end
    endtask

    task automatic test_start_ignored();
        int cyc, xf, unst, lb, bad;
        exp_q.delete();
        arm();
        capture(DEPTH, 1'b0, 40, 500, cyc);
        checks++; if (sample_count !== ADDR_W'(DEPTH)) begin failures++; $display("FAIL start_ign_count got=%0d want=%0d", sample_count, DEPTH); end
        drain(100, xf, unst, lb);
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0)
            if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        checks++; if (xf != int'(DEPTH) || bad != 0) begin failures++; $display("FAIL start_ign_data xfers=%0d mismatches=%0d want %0d/0", xf, bad, DEPTH); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_toggle_enable();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
